// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions: widths, decoded instruction indices, HI/LO sequencer states.
package mips_pkg;

  localparam int unsigned MD_DATA_W = 32;
  localparam int unsigned MD_CNT_W  = 6;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned OP_COUNT  = 54;

  // Decoded instruction indices owned by the HI/LO unit; the decoder defines 0..OP_COUNT-1.
  localparam logic [OP_W-1:0] OP_MFHI  = 6'd18;
  localparam logic [OP_W-1:0] OP_MFLO  = 6'd19;
  localparam logic [OP_W-1:0] OP_MTHI  = 6'd20;
  localparam logic [OP_W-1:0] OP_MTLO  = 6'd21;
  localparam logic [OP_W-1:0] OP_MUL   = 6'd25;
  localparam logic [OP_W-1:0] OP_MULTU = 6'd26;
  localparam logic [OP_W-1:0] OP_DIV   = 6'd27;
  localparam logic [OP_W-1:0] OP_DIVU  = 6'd28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // True for the multi-cycle opcodes that occupy the iterative datapath.
  function automatic logic is_muldiv_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide, one bit per cycle.
module muldiv_core
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W,
  parameter int unsigned CNT_W  = MD_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              iter,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res_hi_c,
  output logic [DATA_W-1:0] res_lo_c,
  output logic              last_c
);

  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opb;
  logic [CNT_W-1:0]  cnt;
  logic              mode_div;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;

  // Next-iteration values; the controller commits these directly on the final iteration.
  always_comb begin
    sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
    diff     = rem_sh - {1'b0, opb};
    res_hi_c = acc_hi;
    res_lo_c = acc_lo;
    if (mode_div) begin
      if (!diff[DATA_W]) begin
        res_hi_c = diff[DATA_W-1:0];
        res_lo_c = {acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        res_hi_c = rem_sh[DATA_W-1:0];
        res_lo_c = {acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      res_hi_c = sum[DATA_W:1];
      res_lo_c = {sum[0], acc_lo[DATA_W-1:1]};
    end
  end

  assign last_c = (cnt == CNT_W'(DATA_W - 1));

  // Operand load on start, then one shift/add or shift/subtract step per iter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      cnt      <= '0;
      mode_div <= 1'b0;
    end else if (start) begin
      acc_hi   <= '0;
      acc_lo   <= a;
      opb      <= b;
      cnt      <= '0;
      mode_div <= is_div;
    end else if (iter) begin
      acc_hi   <= res_hi_c;
      acc_lo   <= res_lo_c;
      cnt      <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer in EX: accepts ops, stalls the pipe, applies signs, owns HI/LO.
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W,
  parameter int unsigned CNT_W  = MD_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [OP_W-1:0]   ins_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] mul_o,
  output logic              done_o
);

  md_state_e         state;
  md_state_e         state_nxt;

  logic [OP_W-1:0]   op_r;
  logic              neg_res;
  logic              neg_rem;

  logic              accept;
  logic              div_zero;
  logic              is_signed;
  logic              is_div;
  logic              start;
  logic              iter;
  logic              commit;

  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;
  logic                last;
  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Decode of the EX-stage instruction; a flush suppresses any accept in the same cycle.
  always_comb begin
    is_signed = (ins_i == OP_MUL) || (ins_i == OP_DIV);
    is_div    = (ins_i == OP_DIV) || (ins_i == OP_DIVU);
    div_zero  = is_div && (rt_i == '0);
    accept    = (state == IDLE) && valid_i && !flush_i && is_muldiv_op(ins_i);
    rs_mag    = (is_signed && rs_i[DATA_W-1]) ? -rs_i : rs_i;
    rt_mag    = (is_signed && rt_i[DATA_W-1]) ? -rt_i : rt_i;
  end

  muldiv_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .iter     (iter),
    .is_div   (is_div),
    .a        (rs_mag),
    .b        (rt_mag),
    .res_hi_c (res_hi),
    .res_lo_c (res_lo),
    .last_c   (last)
  );

  // Sign correction of the unsigned core result.
  always_comb begin
    prod_raw = {res_hi, res_lo};
    prod_fix = neg_res ? -prod_raw : prod_raw;
    quo_fix  = neg_res ? -res_lo : res_lo;
    rem_fix  = neg_rem ? -res_hi : res_hi;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, pipeline stall and datapath sequencing.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    start     = 1'b0;
    iter      = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          if (div_zero) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            start     = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_nxt = IDLE;
        end else begin
          iter = 1'b1;
          if (last) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Opcode and sign bookkeeping captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      op_r    <= ins_i;
      neg_res <= is_signed && (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]);
      neg_rem <= is_signed && rs_i[DATA_W-1];
    end
  end

  // Architectural HI/LO, mul result and done pulse; all land on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_o   <= '0;
      lo_o   <= '0;
      mul_o  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (commit) begin
        done_o <= 1'b1;
        unique case (op_r)
          OP_MUL:   mul_o <= prod_fix[DATA_W-1:0];
          OP_MULTU: begin
            hi_o <= res_hi;
            lo_o <= res_lo;
          end
          OP_DIV: begin
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end
          OP_DIVU: begin
            hi_o <= res_hi;
            lo_o <= res_lo;
          end
          default: ;
        endcase
      end else if (accept && div_zero) begin
        done_o <= 1'b1;
      end else if ((state == IDLE) && valid_i && !flush_i) begin
        if (ins_i == OP_MTHI) hi_o <= rs_i;
        if (ins_i == OP_MTLO) lo_o <= rs_i;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed HI/LO/mul results, stall lengths, flush and reset.
module tb_muldiv_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        flush_i;
  logic [5:0]  ins_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] mul_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  muldiv_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .flush_i (flush_i),
    .ins_i   (ins_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .mul_o   (mul_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_o === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one multi-cycle op, hold it in EX while stalled (and through DONE), then retire it.
  task automatic run_op(input logic [5:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        output int stalls, output logic done_at_end, output logic [31:0] lo_at_end);
    @(posedge clk); #1;
    valid_i = 1'b1; ins_i = ins; rs_i = rs; rt_i = rt;
    stalls = 0;
    @(negedge clk);
    while (stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    done_at_end = done_o;
    lo_at_end   = lo_o;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic write_mt(input logic [5:0] ins, input logic [31:0] val, input string tag);
    @(posedge clk); #1;
    valid_i = 1'b1; ins_i = ins; rs_i = val; rt_i = '0;
    @(negedge clk);
    check(tag, 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // No re-accept of the held op: the cycle after DONE must be idle with no pulse.
  task automatic check_quiet(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  int          stalls;
  logic        dn;
  logic [31:0] lo_d;
  int          done_before;

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ins_i = '0; rs_i = '0; rt_i = '0;
    #12;
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_mul", mul_o, 32'h0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, stalls, dn, lo_d);
    check("multu_stalls", 32'(stalls), 32'd33);
    check("multu_done", 32'(dn), 32'd1);
    check("multu_hi", hi_o, 32'h1);
    check("multu_lo", lo_o, 32'hFFFF_FFFE);
    check_quiet("multu_after");

    // mthi/mtlo, then signed mul -3*7 leaves HI/LO alone
    write_mt(OP_MTHI, 32'hA, "mthi_stall");
    write_mt(OP_MTLO, 32'hB, "mtlo_stall");
    check("mt_hi", hi_o, 32'hA);
    check("mt_lo", lo_o, 32'hB);
    run_op(OP_MUL, 32'hFFFF_FFFD, 32'd7, stalls, dn, lo_d);
    check("mul_stalls", 32'(stalls), 32'd33);
    check("mul_done", 32'(dn), 32'd1);
    check("mul_out", mul_o, 32'hFFFF_FFEB);
    check("mul_hi", hi_o, 32'hA);
    check("mul_lo", lo_o, 32'hB);

    // div -7/2: q=-3, r=-1 (remainder follows dividend)
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, stalls, dn, lo_d);
    check("div_stalls", 32'(stalls), 32'd33);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);

    // div 0x80000000 / -1 overflow case
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stalls, dn, lo_d);
    check("divovf_lo", lo_o, 32'h8000_0000);
    check("divovf_hi", hi_o, 32'h0);

    // divu by zero: one stall, pulse, HI/LO untouched
    run_op(OP_DIVU, 32'd5, 32'd0, stalls, dn, lo_d);
    check("dz_stalls", 32'(stalls), 32'd1);
    check("dz_done", 32'(dn), 32'd1);
    check("dz_hi", hi_o, 32'h0);
    check("dz_lo", lo_o, 32'h8000_0000);
    check_quiet("dz_after");

    // divu 100/7 then mflo: quotient visible at DONE, mflo does not stall
    run_op(OP_DIVU, 32'd100, 32'd7, stalls, dn, lo_d);
    check("divu_stalls", 32'(stalls), 32'd33);
    check("divu_lo_at_done", lo_d, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    valid_i = 1'b1; ins_i = OP_MFLO;
    @(negedge clk);
    check("mflo_stall", 32'(stall_o), 32'd0);
    check("mflo_lo", lo_o, 32'd14);
    @(posedge clk); #1; valid_i = 1'b0;

    // flush coincident with accept: nothing starts
    valid_i = 1'b1; flush_i = 1'b1; ins_i = OP_MULTU; rs_i = 32'd3; rt_i = 32'd3;
    @(negedge clk);
    check("flush_acc_stall0", 32'(stall_o), 32'd0);
    @(posedge clk); #1; valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush_acc_stall1", 32'(stall_o), 32'd0);

    // multu flushed at BUSY cycle 10: back to IDLE, no pulse, HI/LO kept
    done_before = done_seen;
    @(posedge clk); #1;
    valid_i = 1'b1; ins_i = OP_MULTU; rs_i = 32'h0001_0000; rt_i = 32'h0001_0000;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check("flush_busy_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", 32'(stall_o), 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush_no_done", 32'(done_seen - done_before), 32'd0);
    check("flush_hi", hi_o, 32'd2);
    check("flush_lo", lo_o, 32'd14);

    // multu 3*5 after the flush: datapath restarts cleanly
    run_op(OP_MULTU, 32'd3, 32'd5, stalls, dn, lo_d);
    check("multu2_stalls", 32'(stalls), 32'd33);
    check("multu2_hi", hi_o, 32'h0);
    check("multu2_lo", lo_o, 32'hF);

    // reset mid-operation
    @(posedge clk); #1;
    valid_i = 1'b1; ins_i = OP_MULTU; rs_i = 32'd7; rt_i = 32'd9;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_hi", hi_o, 32'h0);
    check("rstmid_lo", lo_o, 32'h0);
    check("rstmid_mul", mul_o, 32'h0);
    check("rstmid_done", 32'(done_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rstmid_lo_later", lo_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
